alu_rr_scheduler: RTL and testbench

- Shares one combinational 32-bit ALU (Sel encodings AND/OR/ADD/SUB/SLT/MUL) among NREQ requesters, e.g. EX stage, branch-compare unit, address unit.
- Round-robin arbitration; grantee's operands registered onto ALU inputs; ALU result captured and returned tagged with requester ID.
- One operation in flight; valid/ready handshakes on both request and response sides.

---
 rtl/alu_sched_pkg.sv | 33 +++
 rtl/rr_pick.sv | 33 +++
 rtl/alu_rr_scheduler.sv | 159 +++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants, types and helpers for the round-robin ALU scheduler.
// Optional perf counters in alu_rr_scheduler are enabled with ALU_SCHED_PERF_EN.
package alu_sched_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [SEL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [SEL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [SEL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [SEL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [SEL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [SEL_W-1:0] ALU_MUL = 4'b0011;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [SEL_W-1:0]  sel;
    } alu_req_t;

    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
        case (sel)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, with wrap.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int unsigned     k;
    logic [IDW-1:0]  k_idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        k_idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            k     = (32'(ptr) + i) % NREQ;
            k_idx = IDW'(k);
            if (!any && valid[k_idx]) begin
                grant[k_idx] = 1'b1;
                idx          = k_idx;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU among NREQ requesters with round-robin arbitration.
// Define ALU_SCHED_PERF_EN to build the op/stall performance counters.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [32*NREQ-1:0]   i_req_op1,
    input  logic [32*NREQ-1:0]   i_req_op2,
    input  logic [4*NREQ-1:0]    i_req_sel,
    output logic [31:0]          o_alu_op1,
    output logic [31:0]          o_alu_op2,
    output logic [3:0]           o_alu_sel,
    input  logic [31:0]          i_alu_result,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [31:0]          o_rsp_data,
    output logic                 o_rsp_zero,
    output logic                 o_rsp_err,
    output logic [31:0]          o_perf_ops,
    output logic [31:0]          o_perf_stall
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     pend_id;
    logic               pend_err;

    logic [NREQ-1:0]    pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    logic               can_accept;
    logic               accept;
    logic               capture;
    logic               rsp_pop;
    alu_req_t           win;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (i_req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Winner payload: AND-OR mux over the one-hot grant
    always_comb begin
        win = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_grant[k]) begin
                win.op1 = i_req_op1[k*DATA_W +: DATA_W];
                win.op2 = i_req_op2[k*DATA_W +: DATA_W];
                win.sel = i_req_sel[k*SEL_W +: SEL_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new grant is possible in IDLE, or in RESP on the cycle the response drains
    always_comb begin
        state_nxt  = state;
        can_accept = 1'b0;
        capture    = 1'b0;
        rsp_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                can_accept = 1'b1;
                if (pick_any) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_pop    = 1'b1;
                    can_accept = 1'b1;
                    state_nxt  = pick_any ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept      = can_accept & pick_any;
    assign o_req_ready = can_accept ? pick_grant : '0;

    // Illegal selects are sequenced as ADD so the ALU never sees an undefined code
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr         <= IDW'(NREQ - 1);
            pend_id     <= '0;
            pend_err    <= 1'b0;
            o_alu_op1   <= '0;
            o_alu_op2   <= '0;
            o_alu_sel   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_data  <= '0;
            o_rsp_zero  <= 1'b0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                ptr       <= pick_idx;
                pend_id   <= pick_idx;
                pend_err  <= ~sel_is_legal(win.sel);
                o_alu_op1 <= win.op1;
                o_alu_op2 <= win.op2;
                o_alu_sel <= sel_is_legal(win.sel) ? win.sel : ALU_ADD;
            end
            if (capture) begin
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= pend_id;
                o_rsp_err   <= pend_err;
                o_rsp_data  <= pend_err ? '0 : i_alu_result;
                o_rsp_zero  <= pend_err | (i_alu_result == '0);
            end else if (rsp_pop) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (rsp_pop) perf_ops <= perf_ops + 32'd1;
            if (state == ST_RESP && !i_rsp_ready) perf_stall <= perf_stall + 32'd1;
        end
    end

    assign o_perf_ops   = perf_ops;
    assign o_perf_stall = perf_stall;
`else
    assign o_perf_ops   = '0;
    assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed, table-driven bench for alu_rr_scheduler with a behavioural ALU.
// Perf-counter checks follow ALU_SCHED_PERF_EN.
module tb_alu_rr_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [NREQ-1:0]     i_req_valid;
    logic [NREQ-1:0]     o_req_ready;
    logic [32*NREQ-1:0]  i_req_op1;
    logic [32*NREQ-1:0]  i_req_op2;
    logic [4*NREQ-1:0]   i_req_sel;
    logic [31:0]         o_alu_op1;
    logic [31:0]         o_alu_op2;
    logic [3:0]          o_alu_sel;
    logic [31:0]         i_alu_result;
    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [IDW-1:0]      o_rsp_id;
    logic [31:0]         o_rsp_data;
    logic                o_rsp_zero;
    logic                o_rsp_err;
    logic [31:0]         o_perf_ops;
    logic [31:0]         o_perf_stall;

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op1    (i_req_op1),
        .i_req_op2    (i_req_op2),
        .i_req_sel    (i_req_sel),
        .o_alu_op1    (o_alu_op1),
        .o_alu_op2    (o_alu_op2),
        .o_alu_sel    (o_alu_sel),
        .i_alu_result (i_alu_result),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_zero   (o_rsp_zero),
        .o_rsp_err    (o_rsp_err),
        .o_perf_ops   (o_perf_ops),
        .o_perf_stall (o_perf_stall)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural ALU; unknown codes return garbage so a leaked select is visible
    always_comb begin
        case (o_alu_sel)
            4'b0000: i_alu_result = o_alu_op1 & o_alu_op2;
            4'b0001: i_alu_result = o_alu_op1 | o_alu_op2;
            4'b0010: i_alu_result = o_alu_op1 + o_alu_op2;
            4'b0110: i_alu_result = o_alu_op1 - o_alu_op2;
            4'b0111: i_alu_result = ($signed(o_alu_op1) < $signed(o_alu_op2)) ? 32'd1 : 32'd0;
            4'b0011: i_alu_result = o_alu_op1 * o_alu_op2;
            default: i_alu_result = 32'hDEAD_BEEF;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic drive_req(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] s);
        i_req_valid[k]     = 1'b1;
        i_req_op1[32*k+:32] = a;
        i_req_op2[32*k+:32] = b;
        i_req_sel[4*k+:4]   = s;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_op1"},   o_alu_op1, 32'd0);
        chk({tag, "_alu_op2"},   o_alu_op2, 32'd0);
        chk({tag, "_alu_sel"},   32'(o_alu_sel), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(o_rsp_id), 32'd0);
        chk({tag, "_rsp_data"},  o_rsp_data, 32'd0);
        chk({tag, "_rsp_zero"},  32'(o_rsp_zero), 32'd0);
        chk({tag, "_rsp_err"},   32'(o_rsp_err), 32'd0);
        chk({tag, "_req_ready"}, 32'(o_req_ready), 32'd0);
        chk({tag, "_perf_ops"},  o_perf_ops, 32'd0);
        chk({tag, "_perf_stall"}, o_perf_stall, 32'd0);
    endtask

    typedef struct {
        int          req;
        logic [3:0]  sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
        logic [3:0]  exp_alu_sel;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    logic [31:0] stall0;
    logic [31:0] ops0;
    int          exp_k;

    initial begin
        vecs[0] = '{0, 4'b0010, 32'd5,         32'd7,         32'd12,         1'b0, 1'b0, 4'b0010};
        vecs[1] = '{1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000,  1'b0, 1'b0, 4'b0000};
        vecs[2] = '{2, 4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF,  1'b0, 1'b0, 4'b0001};
        vecs[3] = '{3, 4'b0111, 32'd3,         32'd8,         32'd1,          1'b0, 1'b0, 4'b0111};
        vecs[4] = '{3, 4'b0111, 32'd8,         32'd3,         32'd0,          1'b1, 1'b0, 4'b0111};
        vecs[5] = '{0, 4'b0011, 32'd6,         32'd7,         32'd42,         1'b0, 1'b0, 4'b0011};
        vecs[6] = '{1, 4'b1111, 32'd5,         32'd5,         32'd0,          1'b1, 1'b1, 4'b0010};
        vecs[7] = '{2, 4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE,  1'b0, 1'b0, 4'b0110};
        vecs[8] = '{1, 4'b0100, 32'd1,         32'd1,         32'd0,          1'b1, 1'b1, 4'b0010};
        vecs[9] = '{0, 4'b0110, 32'd3,         32'd3,         32'd0,          1'b1, 1'b0, 4'b0110};

        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_op1   = '0;
        i_req_op2   = '0;
        i_req_sel   = '0;
        i_rsp_ready = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        i_rst = 1'b0;
        step();

        // Single-requester transactions: accept, one EXEC cycle, then response
        for (int v = 0; v < NVEC; v++) begin
            drive_req(vecs[v].req, vecs[v].op1, vecs[v].op2, vecs[v].sel);
            #1;
            chk($sformatf("v%0d_ready", v), 32'(o_req_ready), 32'(1 << vecs[v].req));
            step();
            i_req_valid = '0;
            #1;
            chk($sformatf("v%0d_exec_ready", v), 32'(o_req_ready), 32'd0);
            chk($sformatf("v%0d_exec_valid", v), 32'(o_rsp_valid), 32'd0);
            chk($sformatf("v%0d_alu_sel", v), 32'(o_alu_sel), 32'(vecs[v].exp_alu_sel));
            chk($sformatf("v%0d_alu_op1", v), o_alu_op1, vecs[v].op1);
            step();
            chk($sformatf("v%0d_rsp_valid", v), 32'(o_rsp_valid), 32'd1);
            chk($sformatf("v%0d_rsp_id", v), 32'(o_rsp_id), 32'(vecs[v].req));
            chk($sformatf("v%0d_rsp_data", v), o_rsp_data, vecs[v].exp_data);
            chk($sformatf("v%0d_rsp_zero", v), 32'(o_rsp_zero), 32'(vecs[v].exp_zero));
            chk($sformatf("v%0d_rsp_err", v), 32'(o_rsp_err), 32'(vecs[v].exp_err));
            i_rsp_ready = 1'b1;
            step();
            i_rsp_ready = 1'b0;
            chk($sformatf("v%0d_rsp_drop", v), 32'(o_rsp_valid), 32'd0);
        end

        // Round robin from reset: all valid, response always accepted
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) drive_req(k, 32'(k + 1), 32'd100, 4'b0010);
        i_rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_k = g % int'(NREQ);
            chk($sformatf("rr%0d_ready", g), 32'(o_req_ready), 32'(1 << exp_k));
            step();
            chk($sformatf("rr%0d_exec_ready", g), 32'(o_req_ready), 32'd0);
            step();
            chk($sformatf("rr%0d_rsp_valid", g), 32'(o_rsp_valid), 32'd1);
            chk($sformatf("rr%0d_rsp_id", g), 32'(o_rsp_id), 32'(exp_k));
            chk($sformatf("rr%0d_rsp_data", g), o_rsp_data, 32'(exp_k + 101));
        end
        i_req_valid = '0;
        step();
        chk("rr_drain_valid", 32'(o_rsp_valid), 32'd0);
        i_rsp_ready = 1'b0;

        // Back-pressure: pointer sits at 0, so req2 wins over req0
        drive_req(2, 32'd9, 32'd9, 4'b0110);
        drive_req(0, 32'd1, 32'd2, 4'b0010);
        #1;
        chk("stall_grant", 32'(o_req_ready), 32'b0100);
        step();
        i_req_valid[2] = 1'b0;
        step();
        stall0 = o_perf_stall;
        ops0   = o_perf_ops;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_ready", c), 32'(o_req_ready), 32'd0);
            chk($sformatf("stall%0d_valid", c), 32'(o_rsp_valid), 32'd1);
            chk($sformatf("stall%0d_id", c), 32'(o_rsp_id), 32'd2);
            chk($sformatf("stall%0d_data", c), o_rsp_data, 32'd0);
            chk($sformatf("stall%0d_zero", c), 32'(o_rsp_zero), 32'd1);
            step();
        end
`ifdef ALU_SCHED_PERF_EN
        chk("perf_stall", o_perf_stall, stall0 + 32'd5);
`else
        chk("perf_stall_tied", o_perf_stall, 32'd0);
`endif
        i_rsp_ready = 1'b1;
        #1;
        chk("unstall_grant", 32'(o_req_ready), 32'b0001);
        step();
        i_req_valid = '0;
`ifdef ALU_SCHED_PERF_EN
        chk("perf_ops", o_perf_ops, ops0 + 32'd1);
`else
        chk("perf_ops_tied", o_perf_ops, 32'd0);
`endif
        step();
        chk("unstall_rsp_id", 32'(o_rsp_id), 32'd0);
        chk("unstall_rsp_data", o_rsp_data, 32'd3);
        step();
        i_rsp_ready = 1'b0;
        chk("unstall_idle_valid", 32'(o_rsp_valid), 32'd0);

        // Reset while an op is in EXEC: discarded, pointer back to NREQ-1
        drive_req(1, 32'd1, 32'd2, 4'b0001);
        #1;
        chk("rstx_grant", 32'(o_req_ready), 32'b0010);
        step();
        i_req_valid = '0;
        i_rst       = 1'b1;
        step();
        i_rst = 1'b0;
        chk_all_zero("rstx");
        step();
        chk("rstx_no_rsp0", 32'(o_rsp_valid), 32'd0);
        step();
        chk("rstx_no_rsp1", 32'(o_rsp_valid), 32'd0);
        for (int k = 0; k < int'(NREQ); k++) drive_req(k, 32'd0, 32'd0, 4'b0010);
        #1;
        chk("rstx_next_grant", 32'(o_req_ready), 32'b0001);
        i_req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
